muladd_vec: RTL and testbench
=============================

Name: muladd_vec

Overview:
Parametrised dot-product engine: computes sum(a[i]*b[i]) for i = 0..N-1.
- a and b are read from two external single-port memories with 1-cycle read latency.
- Control is an ap_ctrl_hs handshake, compatible with our HLS-generated muladd kernels.
- Generalises the fixed 16x16-bit muladd with these additions: vector length, data width, lane count, signedness, saturation, and back-to-back restart.

Parameters:
DATA_W, 16, element width of a and b
N, 16, vector length; must be a multiple of LANES
LANES, 1, elements consumed per cycle per operand; must divide N
ACC_W, 32, width of ap_return
SIGNED, 1, 1 = two's-complement operands, 0 = unsigned
SAT, 0, 0 = wrap the result to ACC_W, 1 = saturate to the ACC_W range

Ports:
ap_clk  in  1  clock; all logic on the rising edge
ap_rst  in  1  synchronous, active-high reset
ap_start  in  1  start request
ap_done  out  1  one-cycle pulse; ap_return valid
ap_idle  out  1  high in IDLE only
ap_ready  out  1  pulses together with ap_done
a_address0  out  clog2(N/LANES) (min 1)  a word address
a_ce0  out  1  a read enable
a_q0  in  LANES*DATA_W  a read data; lane j in bits [j*DATA_W +: DATA_W]
b_address0  out  clog2(N/LANES) (min 1)  b word address
b_ce0  out  1  b read enable
b_q0  in  LANES*DATA_W  b read data, same packing as a_q0
ap_return  out  ACC_W  dot-product result, registered

Behaviour:
- Clock and reset: one clock, ap_clk; reset ap_rst is synchronous and active-high.
- Reset values: state IDLE, ap_idle=1, ap_done=0, ap_ready=0, ce0=0, address0=0, accumulator=0, ap_return=0.
- A reset asserted in any state, including mid-FETCH, takes effect at the next edge and abandons the operation. No done pulse is produced.
- BEATS = N/LANES.
- FSM states: IDLE, FETCH, DRAIN, DONE.
  - IDLE: if ap_start=1, go to FETCH and clear the accumulator and beat counter k.
  - FETCH: a/b_ce0=1 and address0=k; k increments each cycle. Go to DRAIN when k=BEATS-1.
  - DRAIN (1 cycle): ce0=0; the last read data is accumulated.
  - DONE (1 cycle): ap_done=ap_ready=1. Next state is FETCH (accumulator cleared) if ap_start=1, else IDLE.
- Read latency: q0 is valid in the cycle after ce0/address. Each cycle the LANES products of q0 are summed and added to the accumulator.
- ap_start is sampled only in IDLE and DONE; changes during FETCH/DRAIN are ignored.
- Timing: with start sampled in cycle 0 (IDLE), FETCH spans cycles 1..BEATS, DRAIN is cycle BEATS+1, DONE is cycle BEATS+2.
- With ap_start held high, results repeat every BEATS+2 cycles.
- Arithmetic:
  - Products are 2*DATA_W wide, signed or unsigned per SIGNED.
  - Accumulator width INT_W = 2*DATA_W + clog2(N); this is exact, so no internal overflow.
- ap_return loads on entry to DONE and holds until the next DONE or reset.
  - If ACC_W >= INT_W: the sum is sign- or zero-extended.
  - Else if SAT=0: low ACC_W bits.
  - Else: clamp to [min, max] of an ACC_W-bit value of the same signedness.
- Address wrap: address0 never exceeds BEATS-1.

Decomposition:
- Package muladd_pkg holds:
  - state enum (IDLE, FETCH, DRAIN, DONE)
  - clog2 function
  - INT_W and address-width derivation functions
  - a saturate/truncate function.
- One sub-module, muladd_lane_sum: combinational LANES-wide multiply plus adder tree producing an INT_W partial sum. The FSM, counter and accumulator stay in muladd_vec.

Test Plan:
- Basic sum. Defaults, a[i]=i+1, b[i]=1, ap_start pulsed at cycle 0 -> ap_return=136 (0x88); ap_done high only in cycle 18; addresses 0..15 in cycles 1..16.
- Signed operands. SIGNED=1, a[i]=0xFFFF, b[i]=2 -> ap_return=0xFFFFFFE0 (-32). Same data with SIGNED=0 -> 0x001FFFE0.
- Saturation. ACC_W=16, SIGNED=1, a[i]=b[i]=0x7FFF. SAT=1 -> 0x7FFF. SAT=0 -> 0x0010, the low 16 bits of 0x3FFF00010.
- Multi-lane. LANES=4, same data as the basic-sum test -> 136; addresses 0..3; ap_done in cycle 6.
- Back-to-back. ap_start held high, two vector sets swapped in memory between runs -> done pulses in cycles 18 and 36, each with the correct result; ap_idle stays 0 throughout.
- Reset mid-operation. ap_rst in cycle 8 of FETCH -> next cycle ap_idle=1, ce0=0, ap_return=0, no done pulse; a subsequent start yields 136.

Source files
------------

// File: rtl/muladd_pkg.sv
// Shared types and elaboration-time helpers for the muladd_vec dot-product engine.
package muladd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Widest result the fit function can handle; covers INT_W and ACC_W.
  localparam int MAX_W = 128;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Word address width; a one-beat vector still gets a 1-bit address.
  function automatic int addr_width(input int n, input int lanes);
    int w;
    w = clog2(n / lanes);
    return (w < 1) ? 1 : w;
  endfunction

  // Exact accumulator width: one full product plus growth for N terms.
  function automatic int int_width(input int data_w, input int n);
    return 2 * data_w + clog2(n);
  endfunction

  // v is the exact sum already sign/zero-extended to MAX_W. Without sat the
  // caller keeps the low acc_w bits (wrap); with sat it is clamped to the
  // acc_w-bit range of the same signedness first.
  function automatic logic [MAX_W-1:0] fit_result(input logic [MAX_W-1:0] v,
                                                  input int acc_w,
                                                  input bit is_signed,
                                                  input bit sat);
    logic [MAX_W-1:0] hi;
    logic [MAX_W-1:0] lo;
    if (is_signed) begin
      hi = (MAX_W'(1) << (acc_w - 1)) - MAX_W'(1);
      lo = ~hi;
    end else begin
      hi = (MAX_W'(1) << acc_w) - MAX_W'(1);
      lo = '0;
    end
    if (!sat) return v;
    if (is_signed) begin
      if ($signed(v) > $signed(hi)) return hi;
      if ($signed(v) < $signed(lo)) return lo;
    end else begin
      if (v > hi) return hi;
    end
    return v;
  endfunction

endpackage

// File: rtl/muladd_vec_if.sv
// ap_ctrl_hs handshake plus the two single-port memory read ports.
interface muladd_vec_if import muladd_pkg::*; #(
  parameter int DATA_W = 16,
  parameter int N      = 16,
  parameter int LANES  = 1,
  parameter int ACC_W  = 32
);
  localparam int AW = addr_width(N, LANES);

  logic                      ap_start;
  logic                      ap_done;
  logic                      ap_idle;
  logic                      ap_ready;
  logic [AW-1:0]             a_address0;
  logic                      a_ce0;
  logic [LANES*DATA_W-1:0]   a_q0;
  logic [AW-1:0]             b_address0;
  logic                      b_ce0;
  logic [LANES*DATA_W-1:0]   b_q0;
  logic [ACC_W-1:0]          ap_return;

  // Kernel side.
  modport slave (
    input  ap_start, a_q0, b_q0,
    output ap_done, ap_idle, ap_ready, a_address0, a_ce0, b_address0, b_ce0, ap_return
  );

  // Caller / memory side.
  modport master (
    output ap_start, a_q0, b_q0,
    input  ap_done, ap_idle, ap_ready, a_address0, a_ce0, b_address0, b_ce0, ap_return
  );
endinterface

// File: rtl/muladd_lane_sum.sv
// Combinational LANES-wide multiply and sum of one memory beat.
module muladd_lane_sum import muladd_pkg::*; #(
  parameter int DATA_W = 16,
  parameter int LANES  = 1,
  parameter int INT_W  = 36,
  parameter int SIGNED = 1
) (
  input  logic [LANES*DATA_W-1:0] a,
  input  logic [LANES*DATA_W-1:0] b,
  output logic signed [INT_W-1:0] sum
);
  // One extra bit per operand lets a single signed multiplier serve both
  // signed and unsigned modes.
  logic signed [DATA_W:0]     ax   [LANES];
  logic signed [DATA_W:0]     bx   [LANES];
  logic signed [2*DATA_W+1:0] prod [LANES];

  // Extend each lane, multiply, and add all lane products together.
  always_comb begin
    sum = '0;
    for (int j = 0; j < LANES; j++) begin
      ax[j]   = {(SIGNED != 0) & a[j*DATA_W + DATA_W - 1], a[j*DATA_W +: DATA_W]};
      bx[j]   = {(SIGNED != 0) & b[j*DATA_W + DATA_W - 1], b[j*DATA_W +: DATA_W]};
      prod[j] = ax[j] * bx[j];
      sum     = sum + INT_W'(prod[j]);
    end
  end
endmodule

// File: rtl/muladd_vec.sv
// Dot-product engine: streams a/b from 1-cycle-latency memories, accumulates
// LANES products per beat, and returns the fitted sum under ap_ctrl_hs.
module muladd_vec import muladd_pkg::*; #(
  parameter int DATA_W = 16,
  parameter int N      = 16,
  parameter int LANES  = 1,
  parameter int ACC_W  = 32,
  parameter int SIGNED = 1,
  parameter int SAT    = 0
) (
  input logic          ap_clk,
  input logic          ap_rst,
  muladd_vec_if.slave  bus
);
  localparam int BEATS = N / LANES;
  localparam int AW    = addr_width(N, LANES);
  localparam int INT_W = int_width(DATA_W, N);

  state_t                  state;
  state_t                  state_nxt;
  logic [AW-1:0]           k;
  logic                    vld_p1;
  logic signed [INT_W-1:0] lane_sum;
  logic signed [INT_W-1:0] acc_p1;
  logic signed [INT_W-1:0] acc_sum;
  logic [MAX_W-1:0]        acc_ext;
  logic [ACC_W-1:0]        ret_p2;

  muladd_lane_sum #(
    .DATA_W (DATA_W),
    .LANES  (LANES),
    .INT_W  (INT_W),
    .SIGNED (SIGNED)
  ) u_lane_sum (
    .a   (bus.a_q0),
    .b   (bus.b_q0),
    .sum (lane_sum)
  );

  // Read data arriving this cycle is folded into the running sum.
  assign acc_sum = vld_p1 ? acc_p1 + lane_sum : acc_p1;

  // Widen the exact sum according to operand signedness before fitting.
  always_comb begin
    if (SIGNED != 0) acc_ext = MAX_W'(acc_sum);
    else             acc_ext = MAX_W'($unsigned(acc_sum));
  end

  // State register.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state; ap_start only matters in IDLE and DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.ap_start) state_nxt = FETCH;
      FETCH:   if (k == AW'(BEATS - 1)) state_nxt = DRAIN;
      DRAIN:   state_nxt = DONE;
      DONE:    state_nxt = bus.ap_start ? FETCH : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // p0 -> p1: read issued in FETCH, data and valid land one cycle later.
  // p1 -> p2: final sum fitted into ap_return on the way into DONE.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      k      <= '0;
      vld_p1 <= 1'b0;
      acc_p1 <= '0;
      ret_p2 <= '0;
    end else begin
      vld_p1 <= (state == FETCH);
      if (state_nxt == FETCH && state != FETCH) begin
        k      <= '0;
        acc_p1 <= '0;
      end else begin
        if (state == FETCH && state_nxt == FETCH) k <= k + AW'(1);
        acc_p1 <= acc_sum;
      end
      if (state == DRAIN) ret_p2 <= ACC_W'(fit_result(acc_ext, ACC_W, SIGNED != 0, SAT != 0));
    end
  end

  // Handshake and memory-port outputs decoded from the state.
  always_comb begin
    bus.ap_idle    = (state == IDLE);
    bus.ap_done    = (state == DONE);
    bus.ap_ready   = (state == DONE);
    bus.a_ce0      = (state == FETCH);
    bus.b_ce0      = (state == FETCH);
    bus.a_address0 = (state == FETCH) ? k : '0;
    bus.b_address0 = (state == FETCH) ? k : '0;
    bus.ap_return  = ret_p2;
  end
endmodule

// File: tb/tb_muladd_vec.sv
// Directed bench for muladd_vec: five configurations share start/reset, each
// backed by its own 1-cycle-latency memory model.
module tb_muladd_vec;
  logic clk;
  logic rst;
  logic start;
  int   n_total;
  int   n_bad;
  int   cyc;
  int   idle_hi;
  int   dcnt [5];
  int   dcyc [5][4];
  logic [31:0] dret [5][4];

  logic [15:0] ma0 [16];
  logic [15:0] mb0 [16];
  logic [15:0] ma1 [16];
  logic [15:0] mb1 [16];
  logic [15:0] ms  [16];
  logic [63:0] ma4 [4];
  logic [63:0] mb4 [4];

  muladd_vec_if #(.DATA_W(16), .N(16), .LANES(1), .ACC_W(32)) if0 ();
  muladd_vec_if #(.DATA_W(16), .N(16), .LANES(1), .ACC_W(32)) if1 ();
  muladd_vec_if #(.DATA_W(16), .N(16), .LANES(1), .ACC_W(16)) if2 ();
  muladd_vec_if #(.DATA_W(16), .N(16), .LANES(1), .ACC_W(16)) if3 ();
  muladd_vec_if #(.DATA_W(16), .N(16), .LANES(4), .ACC_W(32)) if4 ();

  muladd_vec #(.DATA_W(16), .N(16), .LANES(1), .ACC_W(32), .SIGNED(1), .SAT(0))
    u0 (.ap_clk(clk), .ap_rst(rst), .bus(if0));
  muladd_vec #(.DATA_W(16), .N(16), .LANES(1), .ACC_W(32), .SIGNED(0), .SAT(0))
    u1 (.ap_clk(clk), .ap_rst(rst), .bus(if1));
  muladd_vec #(.DATA_W(16), .N(16), .LANES(1), .ACC_W(16), .SIGNED(1), .SAT(1))
    u2 (.ap_clk(clk), .ap_rst(rst), .bus(if2));
  muladd_vec #(.DATA_W(16), .N(16), .LANES(1), .ACC_W(16), .SIGNED(1), .SAT(0))
    u3 (.ap_clk(clk), .ap_rst(rst), .bus(if3));
  muladd_vec #(.DATA_W(16), .N(16), .LANES(4), .ACC_W(32), .SIGNED(1), .SAT(0))
    u4 (.ap_clk(clk), .ap_rst(rst), .bus(if4));

  assign if0.ap_start = start;
  assign if1.ap_start = start;
  assign if2.ap_start = start;
  assign if3.ap_start = start;
  assign if4.ap_start = start;

  always #5 clk = ~clk;

  // Memory models: data appears the cycle after ce0/address.
  always @(posedge clk) begin
    if (if0.a_ce0) if0.a_q0 <= ma0[if0.a_address0];
    if (if0.b_ce0) if0.b_q0 <= mb0[if0.b_address0];
    if (if1.a_ce0) if1.a_q0 <= ma1[if1.a_address0];
    if (if1.b_ce0) if1.b_q0 <= mb1[if1.b_address0];
    if (if2.a_ce0) if2.a_q0 <= ms[if2.a_address0];
    if (if2.b_ce0) if2.b_q0 <= ms[if2.b_address0];
    if (if3.a_ce0) if3.a_q0 <= ms[if3.a_address0];
    if (if3.b_ce0) if3.b_q0 <= ms[if3.b_address0];
    if (if4.a_ce0) if4.a_q0 <= ma4[if4.a_address0];
    if (if4.b_ce0) if4.b_q0 <= mb4[if4.b_address0];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic rec(input int u, input logic d, input logic r, input logic [31:0] v);
    if (d || r) check($sformatf("ready_eq_done_u%0d", u), r, d);
    if (d) begin
      if (dcnt[u] < 4) begin
        dcyc[u][dcnt[u]] = cyc;
        dret[u][dcnt[u]] = v;
      end
      dcnt[u]++;
    end
  endtask

  task automatic clear_rec();
    for (int u = 0; u < 5; u++) dcnt[u] = 0;
  endtask

  // Advance one cycle and sample all done pulses at the falling edge.
  task automatic step();
    @(negedge clk);
    cyc++;
    rec(0, if0.ap_done, if0.ap_ready, if0.ap_return);
    rec(1, if1.ap_done, if1.ap_ready, if1.ap_return);
    rec(2, if2.ap_done, if2.ap_ready, 32'(if2.ap_return));
    rec(3, if3.ap_done, if3.ap_ready, 32'(if3.ap_return));
    rec(4, if4.ap_done, if4.ap_ready, if4.ap_return);
  endtask

  task automatic load_basic();
    for (int i = 0; i < 16; i++) begin
      ma0[i] = 16'(i + 1);
      mb0[i] = 16'd1;
    end
    for (int w = 0; w < 4; w++) begin
      for (int j = 0; j < 4; j++) begin
        ma4[w][j*16 +: 16] = 16'(4 * w + j + 1);
        mb4[w][j*16 +: 16] = 16'd1;
      end
    end
  endtask

  task automatic load_neg();
    for (int i = 0; i < 16; i++) begin
      ma0[i] = 16'hFFFF;
      mb0[i] = 16'd2;
    end
  endtask

  initial begin
    logic [4:0] exp0;
    logic [2:0] exp4;
    clk = 1'b0;
    rst = 1'b1;
    start = 1'b0;
    n_total = 0;
    n_bad = 0;
    cyc = 0;
    clear_rec();
    load_basic();
    for (int i = 0; i < 16; i++) begin
      ma1[i] = 16'hFFFF;
      mb1[i] = 16'd2;
      ms[i]  = 16'h7FFF;
    end

    repeat (3) @(negedge clk);
    check("rst_idle", if0.ap_idle, 1'b1);
    check("rst_done", if0.ap_done, 1'b0);
    check("rst_ready", if0.ap_ready, 1'b0);
    check("rst_ce", {if0.a_ce0, if0.b_ce0}, 2'b00);
    check("rst_addr", {if0.a_address0, if0.b_address0}, 8'h00);
    check("rst_return", if0.ap_return, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Basic sum, unsigned, saturating, wrapping and 4-lane configurations.
    clear_rec();
    start = 1'b1;
    cyc = 0;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (c == 1) start = 1'b0;
      if (c <= 16) begin
        exp0 = {1'b1, 4'(c - 1)};
        check($sformatf("addr_u0_c%0d", c), {if0.a_ce0, if0.a_address0}, exp0);
      end
      if (c <= 4) begin
        exp4 = {1'b1, 2'(c - 1)};
        check($sformatf("addr_u4_c%0d", c), {if4.b_ce0, if4.b_address0}, exp4);
      end
      if (c == 17) check("drain_ce", if0.a_ce0, 1'b0);
      if (c == 10) check("busy_idle", if0.ap_idle, 1'b0);
    end
    check("basic_done_cnt", dcnt[0], 1);
    check("basic_done_cyc", dcyc[0][0], 18);
    check("basic_ret", dret[0][0], 32'd136);
    check("basic_hold", if0.ap_return, 32'd136);
    check("basic_idle_after", if0.ap_idle, 1'b1);
    check("unsigned_ret", dret[1][0], 32'h001FFFE0);
    check("sat_ret", dret[2][0], 32'h00007FFF);
    check("wrap_ret", dret[3][0], 32'h00000010);
    check("lanes_done_cnt", dcnt[4], 1);
    check("lanes_done_cyc", dcyc[4][0], 6);
    check("lanes_ret", dret[4][0], 32'd136);

    // Signed operands on the default configuration.
    load_neg();
    clear_rec();
    start = 1'b1;
    cyc = 0;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (c == 1) start = 1'b0;
    end
    check("signed_done_cyc", dcyc[0][0], 18);
    check("signed_ret", dret[0][0], 32'hFFFFFFE0);

    // Back-to-back with ap_start held; memory swapped after the first result.
    load_basic();
    clear_rec();
    idle_hi = 0;
    start = 1'b1;
    cyc = 0;
    for (int c = 1; c <= 40; c++) begin
      step();
      if (c <= 36 && if0.ap_idle) idle_hi++;
      if (c == 18) load_neg();
      if (c == 36) start = 1'b0;
    end
    check("b2b_done_cnt", dcnt[0], 2);
    check("b2b_cyc0", dcyc[0][0], 18);
    check("b2b_cyc1", dcyc[0][1], 36);
    check("b2b_ret0", dret[0][0], 32'd136);
    check("b2b_ret1", dret[0][1], 32'hFFFFFFE0);
    check("b2b_idle_cycles", idle_hi, 0);
    check("b2b_idle_end", if0.ap_idle, 1'b1);

    // Reset during FETCH abandons the run with no done pulse.
    load_basic();
    clear_rec();
    start = 1'b1;
    cyc = 0;
    for (int c = 1; c <= 25; c++) begin
      step();
      if (c == 1) start = 1'b0;
      if (c == 8) rst = 1'b1;
      if (c == 9) begin
        rst = 1'b0;
        check("rstmid_idle", if0.ap_idle, 1'b1);
        check("rstmid_ce", if0.a_ce0, 1'b0);
        check("rstmid_return", if0.ap_return, 32'h0);
      end
    end
    check("rstmid_no_done", dcnt[0], 0);

    clear_rec();
    start = 1'b1;
    cyc = 0;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (c == 1) start = 1'b0;
    end
    check("restart_done_cyc", dcyc[0][0], 18);
    check("restart_ret", dret[0][0], 32'd136);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
